instruction_memory_reader: RTL
==============================

// Module: instruction_memory_reader
// PURPOSE
//  Read-back engine for the instruction memory of the single-cycle MIPS core.
//  On start, walks addresses first_address..last_address and returns each word on a valid/ready stream with its address.
//  Keeps a running checksum, so a bench or debug port can confirm a loaded program without probing the memory array.
//  Sits beside the instruction-write port and reads through a dedicated read port while the core is held in reset.
// PARAMETERS
//  DEPTH             256  number of instruction words implemented; legal addresses are 0..DEPTH-1
//  MEM_READ_LATENCY  1    memory read latency in cycles; legal values are 0 (combinational) or 1 (registered)
//  SKIP_ZERO         0    1 = words equal to 32'h0 (unprogrammed) are read and checked but not emitted
// PORTS
//  clk               in   1   clock, rising edge
//  reset             in   1   asynchronous, active-high
//  start             in   1   begin a dump; sampled only in IDLE
//  first_address     in   32  first word address, sampled with start
//  last_address      in   32  last word address (inclusive), sampled with start
//  mem_read_en       out  1   read strobe to the instruction memory
//  mem_read_address  out  32  word address to the instruction memory
//  mem_read_data     in   32  read data, valid MEM_READ_LATENCY cycles after the strobe
//  out_valid         out  1   out_address and out_instruction are valid
//  out_ready         in   1   consumer accepts the word when out_valid & out_ready at a clock edge
//  out_address       out  32  address of the presented word
//  out_instruction   out  32  presented word
//  busy              out  1   high in every state except IDLE
//  done              out  1   one-cycle pulse when a dump ends or is rejected
//  error             out  1   one-cycle pulse, coincident with done, when a range is rejected
//  checksum          out  32  sum mod 2^32 of all words read in the current or last dump
// BEHAVIOUR
//  Reset values: every output is 0; state is IDLE; the address counter is 0.
//  Reset is asynchronous and aborts a dump at any point. No done pulse follows an aborted dump.
//  States: IDLE -> READ -> (WAIT when MEM_READ_LATENCY = 1) -> CAPTURE -> PRESENT -> READ or FINISH -> IDLE.
//  IDLE: start = 1 with first_address <= last_address < DEPTH:
//   - latch both bounds; load the counter with first_address; clear checksum; go to READ.
//  IDLE: start = 1 with first_address > last_address, or last_address >= DEPTH:
//   - pulse done and error in the next cycle; stay in IDLE; leave checksum unchanged.
//  READ: mem_read_en = 1 and mem_read_address = counter for exactly one cycle. mem_read_en is 0 in all other states.
//  WAIT: one idle cycle, present only when MEM_READ_LATENCY = 1.
//  CAPTURE: the data word is registered into out_instruction at the end of this cycle (last cycle of the read latency).
//   - out_address is registered with the counter value at the same edge.
//   - checksum += data, also at the same edge.
//   - The capture happens regardless of SKIP_ZERO.
//  PRESENT: out_valid = 1.
//   - out_address and out_instruction stay stable until the handshake.
//   - out_valid never drops without a handshake.
//   - With SKIP_ZERO = 1 and word == 0: PRESENT is bypassed and the flow goes straight to the next-address decision.
//  Next-address decision, taken at the handshake (or at the bypass):
//   - counter == last_address -> FINISH;
//   - otherwise counter += 1 -> READ.
//   - The compare is made before the increment, so the counter never wraps.
//  FINISH: done = 1 for one cycle; return to IDLE. checksum holds until the next accepted start.
//  start while busy is ignored.
//  out_ready while out_valid = 0 has no effect.
//  Latency, with start sampled at edge N:
//   - mem_read_en is high in cycle N+1;
//   - out_valid rises at N+2+MEM_READ_LATENCY;
//   - throughput is one word per 3+MEM_READ_LATENCY cycles when out_ready is held at 1.
//  first_address == last_address is legal: exactly one word is produced.
// TESTING
//  1. Load ADDI words at addresses 0..2; start(0,2) with out_ready = 1 -> three beats (0,w0), (1,w1), (2,w2); done pulses once; checksum = w0+w1+w2.
//  2. Same dump with out_ready low for 5 cycles on beat 1 -> out_valid and the data stay stable; no beat is lost or repeated.
//  3. start(60,60) -> exactly one beat at address 60 holding the J/ADDI word; done pulses; error stays 0.
//  4. start(5,3), then start(0,DEPTH) -> each gives done and error together for one cycle, no mem_read_en, and busy stays 0.
//  5. SKIP_ZERO = 1; addresses 40..42 hold w, 0, w' -> beats only at 40 and 42; checksum = w+w'.
//  6. Assert reset during PRESENT of beat 2 -> all outputs are 0 at once; the next start(0,1) dumps cleanly from address 0.

Source files
------------

// File: rtl/instruction_memory_reader.sv
// Read-back engine for the instruction memory: walks an address range through a
// dedicated read port, streams each word with its address on a valid/ready
// interface and keeps a running 32-bit checksum of every word read.
module instruction_memory_reader #(
    parameter int unsigned DEPTH            = 256,
    parameter int unsigned MEM_READ_LATENCY = 1,
    parameter bit          SKIP_ZERO        = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] first_address,
    input  logic [31:0] last_address,
    output logic        mem_read_en,
    output logic [31:0] mem_read_address,
    input  logic [31:0] mem_read_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_address,
    output logic [31:0] out_instruction,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] checksum
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StCapture,
        StPresent,
        StFinish
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] counter_q, counter_d;
    logic [31:0] last_q, last_d;
    logic [31:0] out_address_q, out_address_d;
    logic [31:0] out_instruction_q, out_instruction_d;
    logic [31:0] checksum_q, checksum_d;
    logic        reject_q, reject_d;
    logic        at_last;

    // The last-address compare happens before any increment, so the counter never wraps.
    assign at_last = (counter_q == last_q);

    // State register: reset aborts a dump immediately, with no done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: counter, bounds, presented word, checksum, reject pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter_q         <= '0;
            last_q            <= '0;
            out_address_q     <= '0;
            out_instruction_q <= '0;
            checksum_q        <= '0;
            reject_q          <= 1'b0;
        end else begin
            counter_q         <= counter_d;
            last_q            <= last_d;
            out_address_q     <= out_address_d;
            out_instruction_q <= out_instruction_d;
            checksum_q        <= checksum_d;
            reject_q          <= reject_d;
        end
    end

    // Next-state and datapath updates; the address advance is shared by the
    // handshake in PRESENT and the zero-word bypass in CAPTURE.
    always_comb begin
        state_d           = state_q;
        counter_d         = counter_q;
        last_d            = last_q;
        out_address_d     = out_address_q;
        out_instruction_d = out_instruction_q;
        checksum_d        = checksum_q;
        reject_d          = 1'b0;
        mem_read_en       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if ((first_address <= last_address) && (last_address < DEPTH_W)) begin
                        last_d     = last_address;
                        counter_d  = first_address;
                        checksum_d = '0;
                        state_d    = StRead;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            StRead: begin
                mem_read_en = 1'b1;
                state_d     = (MEM_READ_LATENCY == 1) ? StWait : StCapture;
            end
            StWait: begin
                state_d = StCapture;
            end
            StCapture: begin
                out_instruction_d = mem_read_data;
                out_address_d     = counter_q;
                checksum_d        = checksum_q + mem_read_data;
                if (SKIP_ZERO && (mem_read_data == 32'h0)) begin
                    if (at_last) begin
                        state_d = StFinish;
                    end else begin
                        counter_d = counter_q + 32'd1;
                        state_d   = StRead;
                    end
                end else begin
                    state_d = StPresent;
                end
            end
            StPresent: begin
                if (out_ready) begin
                    if (at_last) begin
                        state_d = StFinish;
                    end else begin
                        counter_d = counter_q + 32'd1;
                        state_d   = StRead;
                    end
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Address is held at the counter so a combinational memory still returns
    // the right word during CAPTURE.
    assign mem_read_address = counter_q;
    assign out_valid        = (state_q == StPresent);
    assign out_address      = out_address_q;
    assign out_instruction  = out_instruction_q;
    assign busy             = (state_q != StIdle);
    assign done             = (state_q == StFinish) | reject_q;
    assign error            = reject_q;
    assign checksum         = checksum_q;

endmodule
